mux4_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 8-bit 4:1 mux path among four requesters.

---
 rtl/mux4_bus_arbiter.sv | 88 ++++++++
 tb/tb_mux4_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_bus_arbiter.sv
// Round-robin arbiter granting one of four requesters a bounded burst on a shared
// 8-bit 4:1 mux path; drives the registered mux selects and a bus-valid qualifier.
module mux4_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Req,
    input  logic [3:0] Last,
    output logic [3:0] Grant,
    output logic       Bit1Selecao,
    output logic       Bit2Selecao,
    output logic [1:0] Owner,
    output logic       BusValid
);

    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e          state;
    logic [1:0]      ptr;
    logic [CntW-1:0] beat_cnt;

    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       last_beat;
    logic       release_bus;

    // Scan downward so the candidate closest to ptr is the one that sticks.
    always_comb begin
        pick_idx = ptr;
        cand     = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (Req[cand]) begin
                pick_idx = cand;
            end
        end
    end

    assign last_beat   = (beat_cnt == CntW'(MAX_BURST - 1));
    assign release_bus = !Req[Owner] || Last[Owner] || last_beat;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= StIdle;
            ptr         <= 2'd0;
            beat_cnt    <= '0;
            Grant       <= 4'b0000;
            Owner       <= 2'd0;
            Bit1Selecao <= 1'b0;
            Bit2Selecao <= 1'b0;
            BusValid    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|Req) begin
                        Grant       <= 4'b0001 << pick_idx;
                        Owner       <= pick_idx;
                        Bit1Selecao <= pick_idx[0];
                        Bit2Selecao <= pick_idx[1];
                        BusValid    <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= StBusy;
                    end
                end
                StBusy: begin
                    if (release_bus) begin
                        Grant    <= 4'b0000;
                        BusValid <= 1'b0;
                        ptr      <= Owner + 2'd1;
                        state    <= StGap;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                StGap: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_bus_arbiter.sv
// Directed bench for mux4_bus_arbiter: one instance with MAX_BURST=4, one with
// MAX_BURST=1, both driven from the same Req/Last/Reset.
module tb_mux4_bus_arbiter;

    logic       Clock;
    logic       Reset;
    logic [3:0] Req;
    logic [3:0] Last;

    logic [3:0] Grant;
    logic       Bit1Selecao;
    logic       Bit2Selecao;
    logic [1:0] Owner;
    logic       BusValid;

    logic [3:0] Grant1;
    logic       Bit1Selecao1;
    logic       Bit2Selecao1;
    logic [1:0] Owner1;
    logic       BusValid1;

    int checks;
    int failures;

    mux4_bus_arbiter #(.MAX_BURST(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Last       (Last),
        .Grant      (Grant),
        .Bit1Selecao(Bit1Selecao),
        .Bit2Selecao(Bit2Selecao),
        .Owner      (Owner),
        .BusValid   (BusValid)
    );

    mux4_bus_arbiter #(.MAX_BURST(1)) dut1 (
        .Clock      (Clock),
        .Reset      (Reset),
        .Req        (Req),
        .Last       (Last),
        .Grant      (Grant1),
        .Bit1Selecao(Bit1Selecao1),
        .Bit2Selecao(Bit2Selecao1),
        .Owner      (Owner1),
        .BusValid   (BusValid1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full output check of the MAX_BURST=4 instance; BusValid is expected as |g.
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o);
        chk({tag, ".grant"}, Grant, g);
        chk({tag, ".owner"}, {2'b00, Owner}, {2'b00, o});
        chk({tag, ".sel"}, {2'b00, Bit2Selecao, Bit1Selecao}, {2'b00, o});
        chk({tag, ".valid"}, {3'b000, BusValid}, {3'b000, |g});
    endtask

    task automatic chk_out1(input string tag, input logic [3:0] g, input logic [1:0] o);
        chk({tag, ".grant"}, Grant1, g);
        chk({tag, ".owner"}, {2'b00, Owner1}, {2'b00, o});
        chk({tag, ".sel"}, {2'b00, Bit2Selecao1, Bit1Selecao1}, {2'b00, o});
        chk({tag, ".valid"}, {3'b000, BusValid1}, {3'b000, |g});
        chk({tag, ".onehot0"}, {3'b000, $onehot0(Grant1)}, 4'b0001);
    endtask

    task automatic do_reset();
        Req   = 4'b0000;
        Last  = 4'b0000;
        Reset = 1'b0;
        #3;
        @(negedge Clock);
        Reset = 1'b1;
        step();
    endtask

    initial begin
        logic [1:0] seq [5];
        checks   = 0;
        failures = 0;
        Req      = 4'b0000;
        Last     = 4'b0000;
        Reset    = 1'b0;

        // 1: reset values, async reset mid-burst, priority restarts at 0
        #12;
        chk_out("rst", 4'b0000, 2'd0);
        chk_out1("rst1", 4'b0000, 2'd0);
        @(negedge Clock);
        Reset = 1'b1;
        step();
        Req = 4'b0100;
        step();
        chk_out("t1.grant2", 4'b0100, 2'd2);
        Reset = 1'b0;
        #1;
        chk_out("t1.async", 4'b0000, 2'd0);
        Reset = 1'b1;
        Req   = 4'b1000;
        step();
        chk_out("t1.grant3", 4'b1000, 2'd3);

        // 2: single requester, full burst, gap, idle, re-grant
        do_reset();
        Req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("t2.beat", 4'b0010, 2'd1);
        end
        step();
        chk_out("t2.gap", 4'b0000, 2'd1);
        step();
        chk_out("t2.idle", 4'b0000, 2'd1);
        step();
        chk_out("t2.regrant", 4'b0010, 2'd1);

        // 3: round robin over all four
        do_reset();
        Req = 4'b1111;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                step();
                chk_out("t3.beat", 4'b0001 << seq[n], seq[n]);
            end
            step();
            chk_out("t3.gap", 4'b0000, seq[n]);
            step();
            chk_out("t3.idle", 4'b0000, seq[n]);
        end

        // 4: early end via Last, then via Req drop
        do_reset();
        Req = 4'b0101;
        step();
        chk_out("t4.b1", 4'b0001, 2'd0);
        step();
        chk_out("t4.b2", 4'b0001, 2'd0);
        Last = 4'b0001;
        step();
        chk_out("t4.gap", 4'b0000, 2'd0);
        Last = 4'b0000;
        step();
        chk_out("t4.idle", 4'b0000, 2'd0);
        step();
        chk_out("t4.grant2", 4'b0100, 2'd2);
        Req = 4'b0001;
        step();
        chk_out("t4.drop", 4'b0000, 2'd2);
        step();
        step();
        chk_out("t4.grant0", 4'b0001, 2'd0);

        // 5: Last and Req drop on the final beat give a single release
        do_reset();
        Req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("t5.beat", 4'b0010, 2'd1);
        end
        Last = 4'b0010;
        Req  = 4'b0000;
        step();
        chk_out("t5.gap", 4'b0000, 2'd1);
        Last = 4'b0000;
        Req  = 4'b1110;
        step();
        chk_out("t5.idle", 4'b0000, 2'd1);
        step();
        chk_out("t5.next", 4'b0100, 2'd2);

        // 6: MAX_BURST=1 alternates 0,1 with one-beat grants
        do_reset();
        Req = 4'b0011;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd0; seq[3] = 2'd1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk_out1("t6.beat", 4'b0001 << seq[n], seq[n]);
            step();
            chk_out1("t6.gap", 4'b0000, seq[n]);
            step();
            chk_out1("t6.idle", 4'b0000, seq[n]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
